// File: rtl/enemy_motion_ctrl.sv
// Frame-tick driven motion sequencer for one 32x32 enemy sprite: sweep, descend, die, respawn, game over.
// Optional ENEMY_SPEEDUP_EN: horizontal step grows with killCount up to MAX_BOOST.
module enemy_motion_ctrl #(
  parameter int unsigned X_MIN          = 0,
  parameter int unsigned X_MAX          = 608,
  parameter int unsigned X_START        = 304,
  parameter int unsigned Y_START        = 32,
  parameter int unsigned Y_LIMIT        = 416,
  parameter int unsigned STEP_X         = 2,
  parameter int unsigned STEP_Y         = 16,
  parameter int unsigned RESPAWN_FRAMES = 60
`ifdef ENEMY_SPEEDUP_EN
  ,
  parameter int unsigned MAX_BOOST      = 6
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frameTick,
  input  logic       start,
  input  logic       hit,
  output logic [9:0] posX,
  output logic [9:0] posY,
  output logic       alive,
  output logic       gameOver,
  output logic [7:0] killCount
);

  typedef enum logic [2:0] {StIdle, StMove, StDescend, StDead, StOver} state_e;

  state_e      state;
  logic        dir_left;
  logic [7:0]  respawn_cnt;
  logic [10:0] step;
  logic [10:0] x_right;
  logic [10:0] y_down;

`ifdef ENEMY_SPEEDUP_EN
  always_comb begin
    step = 11'(STEP_X) + {3'b000, killCount};
    if (killCount > 8'(MAX_BOOST)) step = 11'(STEP_X + MAX_BOOST);
  end
`else
  assign step = 11'(STEP_X);
`endif

  // 11-bit sums so edge tests never see a 10-bit wrap
  assign x_right = {1'b0, posX} + step;
  assign y_down  = {1'b0, posY} + 11'(STEP_Y);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      posX        <= 10'(X_START);
      posY        <= 10'(Y_START);
      dir_left    <= 1'b0;
      alive       <= 1'b0;
      gameOver    <= 1'b0;
      killCount   <= 8'd0;
      respawn_cnt <= 8'd0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            state <= StMove;
            alive <= 1'b1;
          end
        end
        StMove, StDescend: begin
          // hit beats a same-cycle frameTick and freezes position/direction
          if (hit) begin
            state       <= StDead;
            alive       <= 1'b0;
            killCount   <= (killCount == 8'hFF) ? killCount : killCount + 8'd1;
            respawn_cnt <= 8'(RESPAWN_FRAMES);
          end else if (frameTick) begin
            if (state == StDescend) begin
              if (y_down >= 11'(Y_LIMIT)) begin
                posY     <= 10'(Y_LIMIT);
                gameOver <= 1'b1;
                state    <= StOver;
              end else begin
                posY  <= y_down[9:0];
                state <= StMove;
              end
            end else if (!dir_left) begin
              if (x_right >= 11'(X_MAX)) begin
                posX     <= 10'(X_MAX);
                dir_left <= 1'b1;
                state    <= StDescend;
              end else begin
                posX <= x_right[9:0];
              end
            end else begin
              if ({1'b0, posX} <= 11'(X_MIN) + step) begin
                posX     <= 10'(X_MIN);
                dir_left <= 1'b0;
                state    <= StDescend;
              end else begin
                posX <= posX - step[9:0];
              end
            end
          end
        end
        StDead: begin
          if (frameTick) begin
            respawn_cnt <= respawn_cnt - 8'd1;
            if (respawn_cnt == 8'd1) begin
              posX     <= 10'(X_START);
              posY     <= 10'(Y_START);
              dir_left <= 1'b0;
              alive    <= 1'b1;
              state    <= StMove;
            end
          end
        end
        StOver: begin
          if (start) begin
            posX      <= 10'(X_START);
            posY      <= 10'(Y_START);
            dir_left  <= 1'b0;
            killCount <= 8'd0;
            gameOver  <= 1'b0;
            state     <= StMove;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
